prog_loader: RTL

//   Byte-stream program loader sitting directly upstream of top_sequential.

---
 rtl/prog_loader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses {base, count, payload} frames, writes
// big-endian words into instruction memory, then pulses start for the CPU.
module prog_loader #(
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned CNT_W     = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        restart,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        start,
    output logic [31:0] address_start,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_HDR_A, S_HDR_N, S_DATA, S_WR, S_GO, S_DONE, S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       bcnt_q, bcnt_d;
    logic [23:0]      shift_q, shift_d;
    logic [31:0]      base_q, base_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             we_q, we_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      astart_q, astart_d;

    logic             accept;
    logic             last_byte;
    logic [31:0]      word;

    assign accept    = in_valid & ready_q;
    assign last_byte = accept & (bcnt_q == 2'd3);
    assign word      = {shift_q, in_data};

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        shift_d  = shift_q;
        base_d   = base_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        astart_d = astart_q;

        // in_ready is only high in the three byte-consuming states
        if (accept) begin
            shift_d = word[23:0];
            bcnt_d  = bcnt_q + 2'd1;
        end

        case (state_q)
            S_HDR_A: begin
                if (last_byte) begin
                    base_d  = word;
                    state_d = (word[1:0] != 2'b00) ? S_ERR : S_HDR_N;
                end
            end
            S_HDR_N: begin
                if (last_byte) begin
                    n_d      = word[CNT_W-1:0];
                    astart_d = base_q;
                    if (word > 32'(MAX_WORDS)) begin
                        state_d = S_ERR;
                    end else if (word == '0) begin
                        state_d = S_GO;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (last_byte) begin
                    addr_d  = base_q + (32'(cnt_q) << 2);
                    wdata_d = word;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q + CNT_W'(1) == n_q) ? S_GO : S_DATA;
            end
            S_GO: begin
                state_d = S_DONE;
            end
            S_DONE, S_ERR: begin
                if (restart) begin
                    state_d = S_HDR_A;
                    bcnt_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_HDR_A;
        endcase

        // Outputs are decoded from the next state so they are registered alongside it
        ready_d = (state_d == S_HDR_A) || (state_d == S_HDR_N) || (state_d == S_DATA);
        we_d    = (state_d == S_WR);
        start_d = (state_d == S_GO);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
        busy_d  = (state_d == S_HDR_N) || (state_d == S_DATA) || (state_d == S_WR) ||
                  (state_d == S_GO) || ((state_d == S_HDR_A) && (bcnt_d != 2'd0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_HDR_A;
            bcnt_q   <= '0;
            shift_q  <= '0;
            base_q   <= '0;
            n_q      <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            we_q     <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            astart_q <= '0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            shift_q  <= shift_d;
            base_q   <= base_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            we_q     <= we_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            astart_q <= astart_d;
        end
    end

    assign in_ready      = ready_q;
    assign imem_we       = we_q;
    assign imem_addr     = addr_q;
    assign imem_wdata    = wdata_q;
    assign start         = start_q;
    assign address_start = astart_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule
